mips_run_ctrl: RTL and testbench

//  Sequencer for the single-cycle MIPS core. Streams a program into instruction memory,

---
 rtl/mips_ctrl_pkg.sv | 23 ++
 rtl/sat_counter.sv | 21 ++
 rtl/mips_run_ctrl.sv | 152 +++++++++++++++
 tb/tb_mips_run_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types for the MIPS run controller: sequencer states, done causes, halt word.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CRST,
    S_RUN,
    S_STEP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_HALT  = 2'b01,
    CAUSE_LIMIT = 2'b10,
    CAUSE_ABORT = 2'b11
  } cause_t;

  // opcode 6'b111111 with all other fields zero
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = &count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             count <= '0;
    else if (clr)           count <= '0;
    else if (en && !at_max) count <= count + W'(1);
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Session sequencer for the single-cycle MIPS core: program load, core reset,
// free-running or single-step execution, and halt/limit/abort termination.
module mips_run_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 32,
  parameter int                CNT_W      = 16,
  parameter logic [DATA_W-1:0] HALT_INSTR = DATA_W'(HALT_WORD),
  parameter int                RST_CYC    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              start_load,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic [CNT_W-1:0]  run_limit,
  input  logic              step_mode,
  input  logic              step,
  input  logic              abort,
  input  logic [DATA_W-1:0] fetch_instr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              core_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        done_cause,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ADDR_W:0]   load_count
);

  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  state_t            state, state_nx;
  cause_t            cause_q, cause_nx;
  logic [CNT_W-1:0]  limit_q;
  logic              step_q;
  logic [ADDR_W:0]   lcnt_q;
  logic [RC_W-1:0]   rcnt_q;

  logic is_halt, start_ok, load_fire, last_word, limit_hit, cnt_clr, cnt_max;

  assign is_halt   = (fetch_instr == HALT_INSTR);
  assign start_ok  = start && (state == S_IDLE || state == S_DONE);
  // abort wins over a concurrent word: no handshake in the abort cycle
  assign load_ready = (state == S_LOAD) && !abort;
  assign load_fire  = load_valid && load_ready;
  // the top address is a forced last word so the write pointer never wraps
  assign last_word  = load_last || (lcnt_q[ADDR_W-1:0] == '1);

  always_comb begin
    core_en = 1'b0;
    case (state)
      S_RUN:   core_en = !is_halt && !abort;
      S_STEP:  core_en = step && !is_halt && !abort;
      default: core_en = 1'b0;
    endcase
  end

  // saturated counter can never reach a further limit
  assign limit_hit = (limit_q != '0) && core_en && !cnt_max &&
                     (cycle_count + CNT_W'(1) == limit_q);

  always_comb begin
    state_nx = state;
    cause_nx = cause_q;
    cnt_clr  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_clr  = 1'b1;
          cause_nx = CAUSE_NONE;
          state_nx = start_load ? S_LOAD : S_CRST;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_nx = S_DONE;
          cause_nx = CAUSE_ABORT;
        end else if (load_fire && last_word) begin
          state_nx = S_CRST;
        end
      end
      S_CRST: begin
        if (abort) begin
          state_nx = S_DONE;
          cause_nx = CAUSE_ABORT;
        end else if (rcnt_q == RC_W'(RST_CYC - 1)) begin
          state_nx = step_q ? S_STEP : S_RUN;
        end
      end
      S_RUN, S_STEP: begin
        if (abort) begin
          state_nx = S_DONE;
          cause_nx = CAUSE_ABORT;
        end else if (is_halt) begin
          state_nx = S_DONE;
          cause_nx = CAUSE_HALT;
        end else if (limit_hit) begin
          state_nx = S_DONE;
          cause_nx = CAUSE_LIMIT;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cause_q <= CAUSE_NONE;
      limit_q <= '0;
      step_q  <= 1'b0;
      lcnt_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state   <= state_nx;
      cause_q <= cause_nx;
      if (start_ok) begin
        limit_q <= run_limit;
        step_q  <= step_mode;
      end
      if (start_ok && start_load) lcnt_q <= '0;
      else if (load_fire)         lcnt_q <= lcnt_q + 1'b1;
      rcnt_q <= (state == S_CRST) ? rcnt_q + 1'b1 : '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_cyc (
    .clk    (clk),
    .reset  (reset),
    .en     (core_en),
    .clr    (cnt_clr),
    .count  (cycle_count),
    .at_max (cnt_max)
  );

  assign imem_we    = load_fire;
  assign imem_addr  = lcnt_q[ADDR_W-1:0];
  assign imem_wdata = load_data;
  assign core_reset = (state == S_IDLE) || (state == S_LOAD) || (state == S_CRST);
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign done_cause = cause_q;
  assign load_count = lcnt_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl with a small stand-in MIPS core and an ISA-level reference model.
module tb_mips_run_ctrl;

  localparam int ADDR_W = 8, DATA_W = 32, CNT_W = 16, RST_CYC = 2;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 0, start_load = 0, load_valid = 0, load_last = 0, step_mode = 0, step = 0, abort = 0;
  logic [DATA_W-1:0] load_data = '0;
  logic [CNT_W-1:0]  run_limit = '0;
  logic [DATA_W-1:0] fetch_instr;
  logic              load_ready, imem_we, core_reset, core_en, busy, done;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic [1:0]        done_cause;
  logic [CNT_W-1:0]  cycle_count;
  logic [ADDR_W:0]   load_count;

  always #5 clk = ~clk;

  mips_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .reset(rst_n), .start(start), .start_load(start_load),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .run_limit(run_limit), .step_mode(step_mode), .step(step), .abort(abort),
    .fetch_instr(fetch_instr), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .core_en(core_en), .busy(busy), .done(done),
    .done_cause(done_cause), .cycle_count(cycle_count), .load_count(load_count));

  int passed = 0, total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ISA subset: addi and add; everything else behaves as a no-op
  function automatic logic [37:0] alu(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    if (ins[31:26] == 6'h08) return {1'b1, ins[20:16], a + {{16{ins[15]}}, ins[15:0]}};
    if (ins[31:26] == 6'h00 && ins[5:0] == 6'h20) return {1'b1, ins[15:11], a + b};
    return '0;
  endfunction

  // stand-in core: instruction memory, PC, register file
  logic [31:0] imem [256];
  logic [31:0] regs [32];
  logic [7:0]  pc;
  logic [37:0] core_res;
  assign fetch_instr = imem[pc];
  assign core_res    = alu(fetch_instr, regs[fetch_instr[25:21]], regs[fetch_instr[20:16]]);

  always @(posedge clk) begin
    if (imem_we) imem[imem_addr] <= imem_wdata;
    if (core_reset) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (core_en) begin
      if (core_res[37] && core_res[36:32] != 5'd0) regs[core_res[36:32]] <= core_res[31:0];
      pc <= pc + 8'd1;
    end
  end

  // reference model and scoreboards
  typedef struct { logic [1:0] cause; int cyc; int lcnt; int en; int pc; logic [31:0] r2; } exp_t;
  exp_t        exp_q [$];
  logic [7:0]  wa_q [$];
  logic [31:0] wd_q [$];
  logic [31:0] ref_imem [256];
  logic [31:0] prog [$];
  int          cur_lcnt = 0;

  function automatic exp_t predict(input int limit);
    exp_t e;
    logic [31:0] m [32];
    logic [37:0] r;
    int p = 0, n = 0;
    for (int i = 0; i < 32; i++) m[i] = '0;
    e.cause = 2'b00;
    for (int k = 0; k < 5000; k++) begin
      if (ref_imem[p] == HALT) begin e.cause = 2'b01; break; end
      r = alu(ref_imem[p], m[ref_imem[p][25:21]], m[ref_imem[p][20:16]]);
      if (r[37] && r[36:32] != 5'd0) m[r[36:32]] = r[31:0];
      p = (p + 1) % 256;
      n++;
      if (limit != 0 && n == limit) begin e.cause = 2'b10; break; end
    end
    e.cyc = n; e.en = n; e.pc = p; e.r2 = m[2]; e.lcnt = cur_lcnt;
    return e;
  endfunction

  // record a load of the first n words of prog into the model
  task automatic ref_load(input int n);
    for (int i = 0; i < n; i++) ref_imem[i] = prog[i];
    cur_lcnt = n;
  endtask

  int   en_cnt = 0;
  logic done_d = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (start && !busy) en_cnt = 0;
    if (core_en) en_cnt++;
    if (imem_we) begin
      if (wa_q.size() == 0) chk("unexpected_imem_write", imem_addr, 0);
      else begin
        chk("imem_addr", imem_addr, wa_q.pop_front());
        chk("imem_wdata", imem_wdata, wd_q.pop_front());
      end
    end
    if (done && !done_d) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("done_cause", done_cause, e.cause);
        chk("cycle_count", cycle_count, e.cyc);
        chk("load_count", load_count, e.lcnt);
        chk("core_en_cycles", en_cnt, e.en);
        chk("core_pc", pc, e.pc);
        chk("core_r2", regs[2], e.r2);
      end
    end
    done_d = done;
  end

  task automatic start_session(input bit ld, input int limit, input bit sm);
    start = 1; start_load = ld; run_limit = CNT_W'(limit); step_mode = sm;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic send_words(input int n, input bit mark_last, input bit gap);
    int t;
    for (int i = 0; i < n; i++) begin
      wa_q.push_back(8'(i)); wd_q.push_back(prog[i]);
      load_valid = 1; load_data = prog[i]; load_last = mark_last && (i == n - 1);
      t = 0;
      @(negedge clk);
      while (!load_ready && t < 100) begin @(negedge clk); t++; end
      if (!load_ready) chk("load_ready_timeout", 0, 1);
      @(posedge clk); #1 load_valid = 0; load_last = 0;
      if (gap && i != n - 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 3000) begin @(negedge clk); t++; end
    if (!done) begin chk("done_timeout", 0, 1); exp_q.delete(); end
    @(posedge clk); #1;
  endtask

  task automatic pulse_step();
    step = 1; @(posedge clk); #1 step = 0;
  endtask

  function automatic logic [31:0] rnd_ins();
    if ($urandom_range(0, 1) == 1)
      return {6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(1, 7)), 16'($urandom_range(0, 20))};
    return {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(1, 7)), 5'd0, 6'h20};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, rc;
    exp_t e;
    for (int i = 0; i < 256; i++) ref_imem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cause", done_cause, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_core_en", core_en, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // full 256-word load, valid every other cycle, no last marker
    prog.delete();
    for (int i = 0; i < 256; i++) prog.push_back(i == 3 ? HALT : rnd_ins());
    ref_load(256);
    exp_q.push_back(predict(0));
    start_session(1, 0, 0);
    send_words(256, 0, 1);
    load_valid = 1; load_data = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1 load_valid = 0;
    wait_done();

    // halting program: addi $1,2 ; addi $3,3 ; add $2,$1,$3 ; halt
    prog.delete();
    prog.push_back(32'h2001_0002); prog.push_back(32'h2003_0003);
    prog.push_back(32'h0023_1020); prog.push_back(HALT);
    ref_load(4);
    exp_q.push_back(predict(0));
    start_session(1, 0, 0);
    send_words(4, 1, 0);
    rc = 0;
    @(negedge clk);
    while (core_reset && rc < 20) begin rc++; @(negedge clk); end
    chk("crst_cycles", rc, RST_CYC);
    wait_done();
    chk("halt_prog_r2", regs[2], 5);
    chk("halt_prog_cycles", cycle_count, 3);

    // cycle limit on a program with no halt
    prog.delete();
    for (int i = 0; i < 6; i++) prog.push_back({6'h08, 5'd0, 5'd4, 16'(i + 1)});
    ref_load(6);
    exp_q.push_back(predict(2));
    start_session(1, 2, 0);
    send_words(6, 1, 0);
    wait_done();
    chk("limit_cause", done_cause, 2);
    chk("limit_pc_bytes", pc * 4, 8);

    // single-step: three pulses five cycles apart
    prog.delete();
    prog.push_back(32'h2001_0002); prog.push_back(32'h2003_0003);
    prog.push_back(32'h0023_1020); prog.push_back(HALT);
    ref_load(4);
    exp_q.push_back(predict(0));
    start_session(1, 0, 1);
    send_words(4, 1, 0);
    t = 0;
    while (core_reset && t < 20) begin @(posedge clk); #1 t++; end
    for (int s = 0; s < 3; s++) begin
      pulse_step();
      repeat (4) @(posedge clk);
      #1;
    end
    wait_done();
    chk("step_count", cycle_count, 3);

    // abort while loading, after two words
    ref_load(2);
    e.cause = 2'b11; e.cyc = 0; e.en = 0; e.pc = 0; e.r2 = '0; e.lcnt = 2;
    exp_q.push_back(e);
    start_session(1, 0, 0);
    send_words(2, 0, 0);
    abort = 1; @(posedge clk); #1 abort = 0;
    wait_done();

    // asynchronous reset in the middle of a run, then rerun without reload
    prog.delete();
    for (int i = 0; i < 30; i++) prog.push_back({6'h08, 5'd2, 5'd2, 16'd1});
    prog.push_back(HALT);
    ref_load(31);
    exp_q.push_back(predict(0));
    start_session(1, 0, 0);
    send_words(31, 1, 0);
    t = 0;
    while (en_cnt < 5 && t < 100) begin @(posedge clk); #1 t++; end
    #2 rst_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_core_reset", core_reset, 1);
    chk("midrst_cycle_count", cycle_count, 0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1;
    cur_lcnt = 0;
    exp_q.push_back(predict(0));
    start_session(0, 0, 0);
    wait_done();
    chk("rerun_r2", regs[2], 30);

    // randomized sessions
    for (int it = 0; it < 14; it++) begin
      bit ld, hh, sm;
      int n, lim;
      ld = 1'($urandom_range(0, 1));
      hh = 1'($urandom_range(0, 1));
      sm = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 10);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back((hh && i == n - 1) ? HALT : rnd_ins());
      lim = (ld && hh) ? $urandom_range(0, 12) : $urandom_range(1, 12);
      if (ld) ref_load(n);
      exp_q.push_back(predict(lim));
      start_session(ld, lim, sm);
      if (ld) send_words(n, 1, 1'($urandom_range(0, 1)));
      if (sm) begin
        t = 0;
        while (!done && t < 100) begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          #1;
          pulse_step();
          t++;
        end
      end
      wait_done();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
